// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_if;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage: 32 iterations, one quotient bit per cycle.
// Presents {remainder, quotient} for the HI/LO write path; handles DIV and DIVU.
module div_seq (
  input  logic clk,
  input  logic rst,
  div_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StByZero = 2'b01,
    StOn     = 2'b10,
    StEnd    = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        div_by_zero;
  logic        iter_done;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] rem_shift, rem_sub;
  logic        rem_ge;
  logic [31:0] quot_fix, rem_fix;

  assign accept      = bus_io.start_i && !bus_io.annul_i;
  assign div_by_zero = (bus_io.opdata2_i == 32'd0);
  assign iter_done   = (cnt_q == 6'd32);

  // Magnitudes; 0x80000000 negates to itself, which is the intended wrap.
  assign op1_abs = (bus_io.signed_div_i && bus_io.opdata1_i[31]) ?
                   (~bus_io.opdata1_i + 32'd1) : bus_io.opdata1_i;
  assign op2_abs = (bus_io.signed_div_i && bus_io.opdata2_i[31]) ?
                   (~bus_io.opdata2_i + 32'd1) : bus_io.opdata2_i;

  assign rem_shift = {rem_q[31:0], dvd_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift - {1'b0, dvs_q};

  assign quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
  assign rem_fix  = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 33'd0;
      quot_q     <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = div_by_zero ? StByZero : StOn;
      end
      StByZero: begin
        state_d = bus_io.annul_i ? StIdle : StEnd;
      end
      StOn: begin
        if (bus_io.annul_i)  state_d = StIdle;
        else if (iter_done)  state_d = StEnd;
      end
      StEnd: begin
        if (!bus_io.start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          dvd_d      = op1_abs;
          dvs_d      = op2_abs;
          neg_quot_d = bus_io.signed_div_i && (bus_io.opdata1_i[31] ^ bus_io.opdata2_i[31]);
          neg_rem_d  = bus_io.signed_div_i && bus_io.opdata1_i[31];
          cnt_d      = 6'd0;
          rem_d      = 33'd0;
          quot_d     = 32'd0;
        end
      end
      StByZero: begin
        result_d = 64'd0;
        ready_d  = !bus_io.annul_i;
      end
      StOn: begin
        if (bus_io.annul_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (iter_done) begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end else begin
          rem_d  = rem_ge ? rem_sub : rem_shift;
          quot_d = {quot_q[30:0], rem_ge};
          dvd_d  = {dvd_q[30:0], 1'b0};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      StEnd: begin
        if (!bus_io.start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign bus_io.result_o = result_q;
  assign bus_io.ready_o  = ready_q;
  assign bus_io.busy_o   = (state_q == StOn) || (state_q == StByZero);

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and operand stability during a run.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  div_if bus ();

  div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic start_req(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
  endtask

  task automatic wait_ready(output int edges, output int busy_cyc, output bit to);
    edges = 0; busy_cyc = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy_o) busy_cyc++;
      if (bus.ready_o) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b result=%h, required 0/0/0",
               bus.ready_o, bus.busy_o, bus.result_o);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b busy=%b, required 0/0", bus.ready_o, bus.busy_o);
    end
  endtask

  task automatic test_divu_basic();
    int e, b; bit to;
    start_req(1'b0, 32'd100, 32'd7);
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 34) begin
      n_fail++; $display("FAIL divu_latency: got %0d edges (timeout=%b), required 34", e, to);
    end
    n_checks++;
    if (b != 33) begin
      n_fail++; $display("FAIL divu_busy_cycles: got %0d, required 33", b);
    end
    n_checks++;
    if (bus.result_o !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL divu_100_7: got %h, required 000000020000000e", bus.result_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL divu_hold: ready=%b result=%h, required 1/000000020000000e",
                         bus.ready_o, bus.result_o);
    end
    drop_start();
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL divu_release: ready=%b result=%h, required 0/0",
                         bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_div_signed();
    int e, b; bit to;
    start_req(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_ready(e, b, to);
    n_checks++;
    if (to || bus.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++; $display("FAIL div_m7_2: got %h (timeout=%b), required fffffffffffffffd",
                         bus.result_o, to);
    end
    drop_start();
    // Back-to-back: a single start-low cycle separates the requests.
    start_req(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 34 || bus.result_o !== 64'h00000001_FFFFFFFD) begin
      n_fail++; $display("FAIL div_7_m2: got %h after %0d edges, required 00000001fffffffd/34",
                         bus.result_o, e);
    end
    drop_start();
  endtask

  task automatic test_by_zero();
    int e, b; bit to;
    start_req(1'b1, 32'd5, 32'd0);
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 2) begin
      n_fail++; $display("FAIL byzero_latency: got %0d edges (timeout=%b), required 2", e, to);
    end
    n_checks++;
    if (bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL byzero_result: got %h, required 0", bus.result_o);
    end
    n_checks++;
    if (b != 1) begin
      n_fail++; $display("FAIL byzero_busy: got %0d cycles, required 1", b);
    end
    drop_start();
  endtask

  task automatic test_edge_cases();
    int e, b; bit to;
    start_req(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_ready(e, b, to);
    n_checks++;
    if (to || bus.result_o !== 64'h00000000_FFFFFFFF) begin
      n_fail++; $display("FAIL divu_max_1: got %h, required 00000000ffffffff", bus.result_o);
    end
    drop_start();
    start_req(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_ready(e, b, to);
    n_checks++;
    if (to || bus.result_o !== 64'h00000000_80000000) begin
      n_fail++; $display("FAIL div_min_m1: got %h, required 0000000080000000", bus.result_o);
    end
    drop_start();
    start_req(1'b1, 32'd0, 32'd9);
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 34 || bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL div_zero_dividend: got %h after %0d edges, required 0/34",
                         bus.result_o, e);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int e, b; bit to; bit seen = 1'b0;
    start_req(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) seen = 1'b1;
    end
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (seen || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL annul_on: seen=%b busy=%b ready=%b result=%h, required 0/0/0/0",
                         seen, bus.busy_o, bus.ready_o, bus.result_o);
    end
    // Annul held in IDLE must block a pending request.
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL annul_idle_block: busy=%b ready=%b, required 0/0",
                         bus.busy_o, bus.ready_o);
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 34 || bus.result_o !== 64'h00000001_00000002) begin
      n_fail++; $display("FAIL after_annul_9_4: got %h after %0d edges, required 0000000100000002/34",
                         bus.result_o, e);
    end
    // Annul in END is ignored.
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000001_00000002) begin
      n_fail++; $display("FAIL annul_end: ready=%b result=%h, required 1/0000000100000002",
                         bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    drop_start();
  endtask

  task automatic test_async_reset();
    int e, b; bit to;
    start_req(1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL async_rst_on: busy=%b ready=%b result=%h, required 0/0/0",
                         bus.busy_o, bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b0;
    start_req(1'b0, 32'd77, 32'd5);
    wait_ready(e, b, to);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (to || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++; $display("FAIL async_rst_end: ready=%b result=%h (timeout=%b), required 0/0",
                         bus.ready_o, bus.result_o, to);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_operand_hold();
    int e, b; bit to;
    start_req(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.signed_div_i = 1'b1; bus.opdata1_i = 32'hDEADBEEF; bus.opdata2_i = 32'd0;
    wait_ready(e, b, to);
    n_checks++;
    if (to || e != 31 || bus.result_o !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL operand_hold: got %h after %0d edges, required 000000020000000e/31",
                         bus.result_o, e);
    end
    drop_start();
  endtask

  initial begin
    bus.start_i = 1'b0; bus.signed_div_i = 1'b0; bus.annul_i = 1'b0;
    bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_by_zero();
    test_edge_cases();
    test_annul();
    test_async_reset();
    test_operand_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
